hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit_pkg.sv | 27 ++
 rtl/hazard_control_unit_if.sv | 42 ++++
 rtl/hazard_control_unit_sat_counter.sv | 23 ++
 rtl/hazard_control_unit.sv | 106 ++++++++++
 tb/tb_hazard_control_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard control unit: FSM encoding,
// timeout default, the hard-wired zero register and the load-use test.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hcu_state_e;

  localparam int         DEFAULT_TIMEOUT_CYCLES = 255;
  localparam logic [4:0] REG_X0                 = 5'd0;

  // A load in execute whose destination feeds a source read in decode.
  function automatic logic load_use_hazard(
    input logic       memRead,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       useRs1,
    input logic [4:0] rs2,
    input logic       useRs2
  );
    return memRead && (rd != REG_X0) &&
           ((useRs1 && (rd == rs1)) || (useRs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle of the hazard control unit: decode/execute/memory
// status in, stall/flush controls and performance counters out.
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       RS1_FD;
  logic [4:0]       RS2_FD;
  logic             UseRS1_FD;
  logic             UseRS2_FD;
  logic [4:0]       RD_DE;
  logic             MemRead_DE;
  logic             BranchTaken_DE;
  logic             DMemReq_EM;
  logic             DMemReady;

  logic             Stall_F;
  logic             Stall_D;
  logic             Stall_E;
  logic             Stall_M;
  logic             Flush_D;
  logic             Flush_E;
  logic             Flush_W;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output RS1_FD, RS2_FD, UseRS1_FD, UseRS2_FD, RD_DE, MemRead_DE,
           BranchTaken_DE, DMemReq_EM, DMemReady,
    input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
           MemTimeout, StallCount, FlushCount
  );

  modport slave (
    input  RS1_FD, RS2_FD, UseRS1_FD, UseRS2_FD, RD_DE, MemRead_DE,
           BranchTaken_DE, DMemReq_EM, DMemReady,
    output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W,
           MemTimeout, StallCount, FlushCount
  );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once full.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: memory-wait freeze with timeout, branch flush and
// load-use stall, all combinational, plus stall/flush performance counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave hz
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT_CYCLES);

  hcu_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, waitInc;
  logic              freeze, normalEval, loadUse;
  logic              frz, branchFlush, luStall;
  logic [CNT_W-1:0]  stallCount, flushCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Ready in MEM_WAIT releases the freeze in the same cycle it arrives.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    freeze     = 1'b0;
    normalEval = 1'b0;
    waitInc    = wait_q + WAIT_W'(1);
    unique case (state_q)
      ST_RUN: begin
        if (hz.DMemReq_EM && !hz.DMemReady) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end else begin
          normalEval = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!hz.DMemReady) begin
          freeze = 1'b1;
          wait_d = waitInc;
          if (waitInc == TIMEOUT_V) begin
            state_d = ST_ERROR;
          end
        end else begin
          normalEval = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign loadUse = load_use_hazard(hz.MemRead_DE, hz.RD_DE,
                                   hz.RS1_FD, hz.UseRS1_FD,
                                   hz.RS2_FD, hz.UseRS2_FD);

  // Reset masks every control; a taken branch squashes the load-use stall.
  assign frz         = !rst && freeze;
  assign branchFlush = !rst && normalEval && hz.BranchTaken_DE;
  assign luStall     = !rst && normalEval && !hz.BranchTaken_DE && loadUse;

  assign hz.Stall_F    = frz | luStall;
  assign hz.Stall_D    = frz | luStall;
  assign hz.Stall_E    = frz;
  assign hz.Stall_M    = frz;
  assign hz.Flush_D    = branchFlush;
  assign hz.Flush_E    = branchFlush | luStall;
  assign hz.Flush_W    = frz;
  assign hz.MemTimeout = (state_q == ST_ERROR);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clr_i   (rst),
    .en_i    (frz | luStall),
    .count_o (stallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .clr_i   (rst),
    .en_i    (branchFlush),
    .count_o (flushCount)
  );

  assign hz.StallCount = stallCount;
  assign hz.FlushCount = flushCount;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: stimulus pushes the expected
// response of a behavioural model, a monitor pops and compares every cycle.
module tb_hazard_control_unit;

  localparam int TIMEOUT = 255;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  hazard_control_unit_if #(.CNT_W(CW)) hz();

  hazard_control_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ctl;
    logic       tmo;
    int         stallCnt;
    int         flushCnt;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference model: are we waiting on memory, for how long, and has the
  // wait budget been exhausted; counters saturate at CMAX.
  bit mWaiting    = 1'b0;
  bit mTimedOut   = 1'b0;
  int mWaitCycles = 0;
  int mStallCnt   = 0;
  int mFlushCnt   = 0;

  // Drives one cycle of inputs, queues the expected response, then advances
  // the model across the following clock edge.
  task automatic applyStimulus(input bit r, input bit [4:0] rs1, input bit [4:0] rs2,
                               input bit u1, input bit u2, input bit [4:0] rd,
                               input bit mr, input bit br, input bit req, input bit rdy,
                               input string tag);
    exp_t e;
    bit lu, fz, bf, ls;
    rst               = r;
    hz.RS1_FD         = rs1;
    hz.RS2_FD         = rs2;
    hz.UseRS1_FD      = u1;
    hz.UseRS2_FD      = u2;
    hz.RD_DE          = rd;
    hz.MemRead_DE     = mr;
    hz.BranchTaken_DE = br;
    hz.DMemReq_EM     = req;
    hz.DMemReady      = rdy;
    lu = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    fz = !r && (mTimedOut || (!rdy && (mWaiting || req)));
    bf = !r && !fz && br;
    ls = !r && !fz && !br && lu;
    e.ctl      = {fz | ls, fz | ls, fz, fz, bf, bf | ls, fz};
    e.tmo      = mTimedOut;
    e.stallCnt = mStallCnt;
    e.flushCnt = mFlushCnt;
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    if (r) begin
      mWaiting    = 1'b0;
      mTimedOut   = 1'b0;
      mWaitCycles = 0;
      mStallCnt   = 0;
      mFlushCnt   = 0;
    end else begin
      if ((fz || ls) && mStallCnt < CMAX) mStallCnt++;
      if (bf && mFlushCnt < CMAX) mFlushCnt++;
      if (!mTimedOut) begin
        if (mWaiting) begin
          if (rdy) begin
            mWaiting = 1'b0;
          end else begin
            mWaitCycles++;
            if (mWaitCycles == TIMEOUT) mTimedOut = 1'b1;
          end
        end else if (req && !rdy) begin
          mWaiting    = 1'b1;
          mWaitCycles = 0;
        end
      end
    end
  endtask

  task automatic idle(input string tag);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, tag);
  endtask

  // Compares every observable output against one scoreboard entry.
  task automatic checkOutput(input exp_t e, input string tag);
    string names[7] = '{"Stall_F", "Stall_D", "Stall_E", "Stall_M", "Flush_D", "Flush_E", "Flush_W"};
    logic [6:0] act;
    act = {hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Stall_M, hz.Flush_D, hz.Flush_E, hz.Flush_W};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (act[6-i] !== e.ctl[6-i]) begin
        failures++;
        $display("[TB] FAIL %s %s: got %b expected %b", tag, names[i], act[6-i], e.ctl[6-i]);
      end
    end
    checks++;
    if (hz.MemTimeout !== e.tmo) begin
      failures++;
      $display("[TB] FAIL %s MemTimeout: got %b expected %b", tag, hz.MemTimeout, e.tmo);
    end
    checks++;
    if ($isunknown(hz.StallCount) || int'(hz.StallCount) != e.stallCnt) begin
      failures++;
      $display("[TB] FAIL %s StallCount: got %0d expected %0d", tag, hz.StallCount, e.stallCnt);
    end
    checks++;
    if ($isunknown(hz.FlushCount) || int'(hz.FlushCount) != e.flushCnt) begin
      failures++;
      $display("[TB] FAIL %s FlushCount: got %0d expected %0d", tag, hz.FlushCount, e.flushCnt);
    end
  endtask

  // Monitor: the DUT presents a fresh response every cycle; sample mid-cycle.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(e, t);
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    rst               = 1'b1;
    hz.RS1_FD         = '0;
    hz.RS2_FD         = '0;
    hz.UseRS1_FD      = 1'b0;
    hz.UseRS2_FD      = 1'b0;
    hz.RD_DE          = '0;
    hz.MemRead_DE     = 1'b0;
    hz.BranchTaken_DE = 1'b0;
    hz.DMemReq_EM     = 1'b0;
    hz.DMemReady      = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset");

    applyStimulus(0, 5, 0, 1, 0, 5, 1, 0, 0, 1, "lu_rs1");
    idle("after_lu_rs1");
    applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, "lu_x0");
    applyStimulus(0, 1, 7, 0, 1, 7, 1, 1, 0, 1, "lu_rs2_branch");
    idle("after_branch");

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset_wait3");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "wait3");
    applyStimulus(0, 3, 0, 1, 0, 3, 1, 0, 1, 1, "wait3_ready");
    idle("after_wait3");

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset_timeout");
    for (int i = 0; i < 256; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "timeout_wait");
    for (int i = 0; i < 3; i++) applyStimulus(0, 2, 0, 1, 0, 2, 1, 1, 0, 1, "error_hold");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "reset_in_error");
    idle("after_error_reset");

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset_sat");
    for (int i = 0; i < 17; i++) applyStimulus(0, 4, 0, 1, 0, 4, 1, 0, 0, 1, "stall_sat");
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "flush_sat");
    idle("after_sat");

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(bit'($urandom_range(0, 31) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
                    "random");
    end

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
